// File: rtl/syncfifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through read and sticky error flags.
module syncfifo_prog #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wrAccept, rdAccept;
  logic [WIDTH-1:0] headWord;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wrAccept = wr_en && !full;
  assign rdAccept = rd_en && !empty;
  assign headWord = mem[rdPtr_q[AW-1:0]];

  // rdData_q holds the last popped word in both modes; FWFT shows the head instead while non-empty
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    rdData_d    = rdData_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wrAccept) wrPtr_d = wrPtr_q + PW'(1);
    if (rdAccept) begin
      rdPtr_d  = rdPtr_q + PW'(1);
      rdData_d = headWord;
    end
    case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      rdData_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      rdData_q    <= rdData_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wrAccept) mem[wrPtr_q[AW-1:0]] <= din;
  end

  generate
    if (FWFT != 0) begin : gFwft
      assign dout = empty ? rdData_q : headWord;
    end else begin : gStd
      assign dout = rdData_q;
    end
  endgenerate

endmodule

// File: tb/tb_syncfifo_prog.sv
// Randomized and directed bench for syncfifo_prog: a standard and an FWFT instance
// share stimulus and are checked every cycle against a queue-based reference model.
module tb_syncfifo_prog;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wrEn = 1'b0;
  logic             rdEn = 1'b0;
  logic             clrErr = 1'b0;
  logic [WIDTH-1:0] din = '0;

  logic [WIDTH-1:0] dout0, dout1;
  logic             full0, empty0, af0, ae0, ovf0, udf0;
  logic             full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0]       count0, count1;

  int nChecks = 0;
  int nFails  = 0;

  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] modelDout;
  logic             modelOvf, modelUdf;

  always #5 clk = ~clk;

  syncfifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wrEn), .din(din), .rd_en(rdEn), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0), .clr_err(clrErr));

  syncfifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wrEn), .din(din), .rd_en(rdEn), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1), .clr_err(clrErr));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour: pop happens against the pre-edge occupancy, then push
  task automatic modelStep(input logic rst, input logic wr, input logic rd,
                           input logic [WIDTH-1:0] d, input logic clr);
    int  sz;
    bit  wasFull, wasEmpty;
    if (rst) begin
      modelQ.delete();
      modelDout = '0;
      modelOvf  = 1'b0;
      modelUdf  = 1'b0;
      return;
    end
    sz       = modelQ.size();
    wasFull  = (sz == DEPTH);
    wasEmpty = (sz == 0);
    if (rd && !wasEmpty) modelDout = modelQ.pop_front();
    if (wr && !wasFull)  modelQ.push_back(d);
    if (clr) begin
      modelOvf = 1'b0;
      modelUdf = 1'b0;
    end
    if (wr && wasFull)  modelOvf = 1'b1;
    if (rd && wasEmpty) modelUdf = 1'b1;
  endtask

  task automatic compareAll();
    int sz;
    logic [WIDTH-1:0] expFwft;
    sz = modelQ.size();
    expFwft = (sz > 0) ? modelQ[0] : modelDout;
    checkOutput("count",       32'(count0), 32'(sz));
    checkOutput("full",        32'(full0),  32'(sz == DEPTH));
    checkOutput("empty",       32'(empty0), 32'(sz == 0));
    checkOutput("almostFull",  32'(af0),    32'(sz >= AF));
    checkOutput("almostEmpty", 32'(ae0),    32'(sz <= AE));
    checkOutput("overflow",    32'(ovf0),   32'(modelOvf));
    checkOutput("underflow",   32'(udf0),   32'(modelUdf));
    checkOutput("doutStd",     32'(dout0),  32'(modelDout));
    checkOutput("countFwft",   32'(count1), 32'(sz));
    checkOutput("emptyFwft",   32'(empty1), 32'(sz == 0));
    checkOutput("flagsFwft",   32'({full1, af1, ae1, ovf1, udf1}),
                32'({sz == DEPTH, sz >= AF, sz <= AE, modelOvf, modelUdf}));
    checkOutput("doutFwft",    32'(dout1),  32'(expFwft));
  endtask

  task automatic applyStimulus(input logic rstN, input logic wr, input logic rd,
                               input logic [WIDTH-1:0] d, input logic clr);
    reset_n = rstN;
    wrEn    = wr;
    rdEn    = rd;
    din     = d;
    clrErr  = clr;
    @(posedge clk);
    modelStep(!rstN, wr, rd, d, clr);
    #1;
    compareAll();
  endtask

  initial begin
    int wrProb, rdProb;
    logic [WIDTH-1:0] seqData;

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-operation with both requests active
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Fill to full, overflow, drain, underflow
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(i), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h0F, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h42, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous ops at count 7, then wrap-around at count 3
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    seqData = 8'h80;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, seqData, 1'b0);
      seqData = seqData + 8'd1;
    end

    // FWFT head visibility from empty
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random phases with varying write/read pressure
    for (int p = 0; p < 20; p++) begin
      wrProb = $urandom_range(10, 90);
      rdProb = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        applyStimulus(($urandom_range(0, 199) != 0),
                      ($urandom_range(0, 99) < wrProb),
                      ($urandom_range(0, 99) < rdProb),
                      8'($urandom()),
                      ($urandom_range(0, 15) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
